alu_ctrl_stage: RTL

//  Registered ALU-control decode for the ID/EX boundary of the pipelined MIPS core.

---
 rtl/alu_ctrl_stage.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/alu_ctrl_stage.sv
// alu_ctrl_stage: registered ALU-control decode at ID/EX with a mult/div sequencer that requests pipeline stalls
module alu_ctrl_stage #(
  parameter int CTRL_W  = 4,
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 32,
  parameter int CNT_W   = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic              valid_in,
  input  logic [1:0]        ALUop,
  input  logic [5:0]        func,
  input  logic [5:0]        opcode,
  output logic [CTRL_W-1:0] alu_ctrl,
  output logic              valid_out,
  output logic              illegal,
  output logic              md_start,
  output logic              md_busy,
  output logic              md_done,
  output logic              stall_req
);
  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_SLL  = 4'b0100;
  localparam logic [3:0] OP_SRL  = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_SRA  = 4'b1000;
  localparam logic [3:0] OP_SLTU = 4'b1001;
  localparam logic [3:0] OP_LUI  = 4'b1010;
  localparam logic [3:0] OP_NOR  = 4'b1100;
  localparam logic [3:0] OP_MULT = 4'b1101;
  localparam logic [3:0] OP_DIV  = 4'b1110;
  localparam logic [CTRL_W-1:0] ADD_W = CTRL_W'(OP_ADD);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [CTRL_W-1:0] alu_ctrl_q, alu_ctrl_d;
  logic              valid_q, illegal_q, illegal_d;
  logic              md_start_q, md_busy_q, md_done_q, stall_req_q;
  logic [3:0]        code;
  logic              unknown, is_mul, is_div;
  logic              hold, load, launch;
  logic [CNT_W-1:0]  lat_m1;

  // Combinational decode of ALUop/func/opcode into an operation code
  always_comb begin
    code    = OP_ADD;
    unknown = 1'b0;
    is_mul  = 1'b0;
    is_div  = 1'b0;
    case (ALUop)
      2'b00: code = OP_ADD;
      2'b01: code = OP_SUB;
      2'b10:
        case (func)
          6'b100000, 6'b100001: code = OP_ADD;
          6'b100010, 6'b100011: code = OP_SUB;
          6'b100100: code = OP_AND;
          6'b100101: code = OP_OR;
          6'b100110: code = OP_XOR;
          6'b100111: code = OP_NOR;
          6'b101010: code = OP_SLT;
          6'b101011: code = OP_SLTU;
          6'b000000: code = OP_SLL;
          6'b000010: code = OP_SRL;
          6'b000011: code = OP_SRA;
          6'b011000, 6'b011001: begin
            code   = OP_MULT;
            is_mul = 1'b1;
          end
          6'b011010, 6'b011011: begin
            code   = OP_DIV;
            is_div = 1'b1;
          end
          default: unknown = 1'b1;
        endcase
      default:
        case (opcode)
          6'b001000, 6'b001001: code = OP_ADD;
          6'b001010: code = OP_SLT;
          6'b001011: code = OP_SLTU;
          6'b001100: code = OP_AND;
          6'b001101: code = OP_OR;
          6'b001110: code = OP_XOR;
          6'b001111: code = OP_LUI;
          default: unknown = 1'b1;
        endcase
    endcase
  end

  assign alu_ctrl_d = CTRL_W'(code);
  assign illegal_d  = valid_in & unknown;
  // The MDU's own stall request also freezes this stage so the mult/div stays in EX
  assign hold       = stall | stall_req_q;
  assign load       = !flush && !hold;
  assign launch     = load && valid_in && (is_mul || is_div);
  assign lat_m1     = is_div ? CNT_W'(DIV_LAT - 1) : CNT_W'(MUL_LAT - 1);

  // Pipeline register plus MDU sequencer; flush squashes the instruction but never aborts the MDU
  always_ff @(posedge clk) begin
    if (reset) begin
      alu_ctrl_q  <= ADD_W;
      valid_q     <= 1'b0;
      illegal_q   <= 1'b0;
      md_start_q  <= 1'b0;
      md_busy_q   <= 1'b0;
      md_done_q   <= 1'b0;
      stall_req_q <= 1'b0;
      state_q     <= IDLE;
      cnt_q       <= '0;
    end else begin
      if (flush) begin
        alu_ctrl_q <= ADD_W;
        valid_q    <= 1'b0;
        illegal_q  <= 1'b0;
      end else if (!hold) begin
        alu_ctrl_q <= alu_ctrl_d;
        valid_q    <= valid_in;
        illegal_q  <= illegal_d;
      end
      md_start_q <= 1'b0;
      md_done_q  <= 1'b0;
      case (state_q)
        BUSY:
          if (cnt_q == '0) begin
            state_q     <= DONE;
            md_busy_q   <= 1'b0;
            stall_req_q <= 1'b0;
            md_done_q   <= 1'b1;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        default:
          if (launch) begin
            state_q     <= BUSY;
            cnt_q       <= lat_m1;
            md_start_q  <= 1'b1;
            md_busy_q   <= 1'b1;
            stall_req_q <= 1'b1;
          end else begin
            state_q <= IDLE;
          end
      endcase
    end
  end

  assign alu_ctrl  = alu_ctrl_q;
  assign valid_out = valid_q;
  assign illegal   = illegal_q;
  assign md_start  = md_start_q;
  assign md_busy   = md_busy_q;
  assign md_done   = md_done_q;
  assign stall_req = stall_req_q;
endmodule
